// File: rtl/wall_tile_lookup_if.sv
`timescale 1ns/1ps
// Raster-in / map-write / raster-out bundle for the wall tile lookup.
// Latency: n/a (wiring only).
// Backpressure: none; the bundle streams one pixel per clock.
interface wall_tile_lookup_if;
  logic [10:0]        hcount;
  logic [9:0]         vcount;
  logic               hsync;
  logic               vsync;
  logic               blank;
  logic signed [11:0] screenx;
  logic signed [12:0] screeny;
  logic               map_we;
  logic [10:0]        map_addr;
  logic               map_data;
  logic               exists;
  logic [10:0]        hcount_out;
  logic [9:0]         vcount_out;
  logic               hsync_out;
  logic               vsync_out;
  logic               blank_out;

  modport master (
    output hcount, vcount, hsync, vsync, blank, screenx, screeny,
    output map_we, map_addr, map_data,
    input  exists, hcount_out, vcount_out, hsync_out, vsync_out, blank_out
  );

  modport slave (
    input  hcount, vcount, hsync, vsync, blank, screenx, screeny,
    input  map_we, map_addr, map_data,
    output exists, hcount_out, vcount_out, hsync_out, vsync_out, blank_out
  );
endinterface

// File: rtl/wall_tile_lookup.sv
`timescale 1ns/1ps
// Per-pixel climbing-wall "exists" flag from raster position, camera scroll and a 1-bit tile map.
// Latency: 3 clocks from raster inputs to exists and all *_out timing signals.
// Backpressure: none; accepts and emits one pixel every clock, map writes are never stalled.
module wall_tile_lookup #(
  parameter int map_width   = 48,
  parameter int map_height  = 20,
  parameter int tile_log2   = 6,
  parameter int hold_margin = 4
) (
  input  logic               clock_65mhz,
  input  logic               reset,
  wall_tile_lookup_if.slave  bus
);

  localparam int MAP_SIZE = map_width * map_height;
  localparam int AW       = $clog2(MAP_SIZE);
  localparam int TILE     = 1 << tile_log2;
  localparam int RW       = 14 - tile_log2;

  localparam logic [13:0]          MAP_W_PX = 14'(map_width << tile_log2);
  localparam logic [13:0]          MAP_H_PX = 14'(map_height << tile_log2);
  localparam logic [10:0]          MAP_LAST = 11'(MAP_SIZE);
  localparam logic [tile_log2-1:0] HOLD_LO  = tile_log2'(hold_margin);
  localparam logic [tile_log2-1:0] HOLD_HI  = tile_log2'(TILE - hold_margin);

  typedef struct packed {
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
  } raster_t;

  localparam raster_t RASTER_RST = '{hcount: 11'd0, vcount: 10'd0,
                                     hsync: 1'b0, vsync: 1'b0, blank: 1'b1};

  // Camera scroll, frozen for the whole visible frame.
  logic signed [11:0] sx;
  logic signed [12:0] sy;

  // World coordinates in 14-bit two's complement; the sign bit marks "below/left of the map".
  logic [13:0]          wx_c;
  logic [13:0]          wy_c;
  logic                 inmap_c;
  logic [RW-1:0]        col_c;
  logic [RW-1:0]        row_c;
  logic [AW-1:0]        addr_c;

  raster_t              rast_in;
  raster_t              rast1, rast2, rast3;
  logic [AW-1:0]        addr1;
  logic                 inmap1, inmap2;
  logic [tile_log2-1:0] lx1, ly1, lx2, ly2;
  logic                 ramq;
  logic                 exists_q;

  logic                 mem [0:MAP_SIZE-1];

  // Take the new camera position only on the first vertical-blank line so a frame never tears.
  always_ff @(posedge clock_65mhz) begin
    if (reset) begin
      sx <= '0;
      sy <= '0;
    end else if (bus.hcount == 11'd0 && bus.vcount == 10'd768) begin
      sx <= bus.screenx;
      sy <= bus.screeny;
    end
  end

  // Screen-to-world mapping; y flips so that world y grows upward from the ground line.
  always_comb begin
    wx_c    = {3'b000, bus.hcount} + {{2{sx[11]}}, sx};
    wy_c    = 14'd768 - {4'b0000, bus.vcount} - {sy[12], sy};
    inmap_c = !wx_c[13] && !wy_c[13] && (wx_c < MAP_W_PX) && (wy_c < MAP_H_PX);
    col_c   = wx_c[13:tile_log2];
    row_c   = wy_c[13:tile_log2];
    addr_c  = '0;
    if (inmap_c) begin
      addr_c = AW'(row_c) * AW'(map_width) + AW'(col_c);
    end
    rast_in = '{hcount: bus.hcount, vcount: bus.vcount,
                hsync: bus.hsync, vsync: bus.vsync, blank: bus.blank};
  end

  // Stage 1: register tile address and in-tile offsets.
  always_ff @(posedge clock_65mhz) begin
    if (reset) begin
      addr1  <= '0;
      inmap1 <= 1'b0;
      lx1    <= '0;
      ly1    <= '0;
      rast1  <= RASTER_RST;
    end else begin
      addr1  <= addr_c;
      inmap1 <= inmap_c;
      lx1    <= wx_c[tile_log2-1:0];
      ly1    <= wy_c[tile_log2-1:0];
      rast1  <= rast_in;
    end
  end

  // Map write port; out-of-range tile indices are dropped. Contents survive reset.
  always_ff @(posedge clock_65mhz) begin
    if (bus.map_we && bus.map_addr < MAP_LAST) begin
      mem[bus.map_addr[AW-1:0]] <= bus.map_data;
    end
  end

  // Stage 2: read-first map lookup with the tile offsets carried alongside.
  always_ff @(posedge clock_65mhz) begin
    if (reset) begin
      ramq   <= 1'b0;
      inmap2 <= 1'b0;
      lx2    <= '0;
      ly2    <= '0;
      rast2  <= RASTER_RST;
    end else begin
      ramq   <= mem[addr1];
      inmap2 <= inmap1;
      lx2    <= lx1;
      ly2    <= ly1;
      rast2  <= rast1;
    end
  end

  // Stage 3: solid tile minus its empty border, suppressed during blanking.
  always_ff @(posedge clock_65mhz) begin
    if (reset) begin
      exists_q <= 1'b0;
      rast3    <= RASTER_RST;
    end else begin
      exists_q <= ramq && inmap2 &&
                  (lx2 >= HOLD_LO) && (lx2 < HOLD_HI) &&
                  (ly2 >= HOLD_LO) && (ly2 < HOLD_HI) &&
                  !rast2.blank;
      rast3    <= rast2;
    end
  end

  assign bus.exists     = exists_q;
  assign bus.hcount_out = rast3.hcount;
  assign bus.vcount_out = rast3.vcount;
  assign bus.hsync_out  = rast3.hsync;
  assign bus.vsync_out  = rast3.vsync;
  assign bus.blank_out  = rast3.blank;

endmodule

// File: tb/tb_wall_tile_lookup.sv
`timescale 1ns/1ps
// Bench for wall_tile_lookup: directed raster vectors against a pixel-level model.
// Latency: expects every output 3 clocks after its input pixel.
// Backpressure: none; one pixel is driven per clock.
module tb_wall_tile_lookup;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wall_tile_lookup_if bus();

  wall_tile_lookup dut (
    .clock_65mhz (clk),
    .reset       (reset),
    .bus         (bus)
  );

  typedef struct packed {
    logic        ex;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
  } out_t;

  localparam out_t RST = '{ex: 1'b0, h: 11'd0, v: 10'd0, hs: 1'b0, vs: 1'b0, bl: 1'b1};

  int   checks = 0;
  int   errors = 0;

  // Model state: tile map, latched camera, expected outputs still in flight.
  bit   model_map [0:959];
  int   msx = 0;
  int   msy = 0;
  out_t pend [$];
  out_t cur;
  bit   have = 1'b0;

  // What the pixel must look like, straight from the tile-map rules.
  function automatic bit exp_exists(int h, int v, bit bl, int sx, int sy);
    int wx, wy, lx, ly;
    wx = h + sx;
    wy = 768 - v - sy;
    if (bl) return 1'b0;
    if (wx < 0 || wy < 0 || wx >= 48 * 64 || wy >= 20 * 64) return 1'b0;
    lx = wx % 64;
    ly = wy % 64;
    if (!model_map[(wy / 64) * 48 + wx / 64]) return 1'b0;
    return (lx >= 4 && lx < 60 && ly >= 4 && ly < 60);
  endfunction

  // Model advances on each active edge, seeing the same inputs the DUT samples.
  always @(posedge clk) begin
    out_t e;
    if (bus.map_we && bus.map_addr < 11'd960) model_map[bus.map_addr] = bus.map_data;
    if (reset) begin
      msx = 0;
      msy = 0;
      pend.delete();
      pend.push_back(RST);
      pend.push_back(RST);
      cur  = RST;
      have = 1'b1;
    end else if (have) begin
      e.ex = exp_exists(int'(bus.hcount), int'(bus.vcount), bus.blank, msx, msy);
      e.h  = bus.hcount;
      e.v  = bus.vcount;
      e.hs = bus.hsync;
      e.vs = bus.vsync;
      e.bl = bus.blank;
      pend.push_back(e);
      cur = pend.pop_front();
      if (bus.hcount == 11'd0 && bus.vcount == 10'd768) begin
        msx = bus.screenx;
        msy = bus.screeny;
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    out_t got;
    if (have) begin
      got = '{ex: bus.exists, h: bus.hcount_out, v: bus.vcount_out,
              hs: bus.hsync_out, vs: bus.vsync_out, bl: bus.blank_out};
      checks++;
      if (got !== cur) begin
        errors++;
        $display("FAIL pipeline t=%0t got ex=%b h=%0d v=%0d hs=%b vs=%b bl=%b want ex=%b h=%0d v=%0d hs=%b vs=%b bl=%b",
                 $time, got.ex, got.h, got.v, got.hs, got.vs, got.bl,
                 cur.ex, cur.h, cur.v, cur.hs, cur.vs, cur.bl);
      end
    end
  end

  task automatic pix(int h, int v);
    bus.hcount = 11'(h);
    bus.vcount = 10'(v);
    bus.blank  = (h >= 1024 || v >= 768);
    bus.hsync  = (h >= 1048 && h < 1184);
    bus.vsync  = (v >= 771 && v < 777);
    @(posedge clk);
    #2;
  endtask

  task automatic wr(int a, bit d, int h, int v);
    bus.map_we   = 1'b1;
    bus.map_addr = 11'(a);
    bus.map_data = d;
    pix(h, v);
    bus.map_we   = 1'b0;
  endtask

  task automatic latch(int sx, int sy);
    bus.screenx = 12'(sx);
    bus.screeny = 13'(sy);
    pix(0, 768);
  endtask

  // Hold one pixel for three clocks and check the hand-computed result.
  task automatic lit(string name, int h, int v, bit want);
    pix(h, v);
    pix(h, v);
    pix(h, v);
    @(negedge clk);
    checks++;
    if (bus.exists !== want || bus.hcount_out !== 11'(h) || bus.vcount_out !== 10'(v)) begin
      errors++;
      $display("FAIL %s got exists=%b h=%0d v=%0d want exists=%b h=%0d v=%0d",
               name, bus.exists, bus.hcount_out, bus.vcount_out, want, h, v);
    end
  endtask

  task automatic check_bit(string name, bit got, bit want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.screenx  = '0;
    bus.screeny  = '0;
    bus.map_we   = 1'b0;
    bus.map_addr = '0;
    bus.map_data = 1'b0;
    pix(0, 0);
    pix(0, 0);
    @(negedge clk);
    check_bit("reset_exists", bus.exists, 1'b0);
    check_bit("reset_blank_out", bus.blank_out, 1'b1);
    check_bit("reset_hcount_out", bus.hcount_out == 11'd0, 1'b1);
    reset = 1'b0;

    // Start from a known-empty map.
    for (int a = 0; a < 960; a++) wr(a, 1'b0, 1100, 800);

    // Empty map: timing delay line across visible, hsync and vblank regions.
    foreach (pend[i]) ;
    for (int v = 700; v <= 772; v += 24)
      for (int h = 0; h < 1344; h++) pix(h, v);

    // Single solid tile at the origin, camera at zero.
    wr(0, 1'b1, 1100, 800);
    latch(0, 0);
    check_bit("model_pin_in", exp_exists(4, 764, 1'b0, 0, 0), 1'b1);
    check_bit("model_pin_out", exp_exists(60, 764, 1'b0, 0, 0), 1'b0);
    for (int v = 707; v <= 766; v++)
      for (int h = 0; h < 70; h++) pix(h, v);
    lit("hold_in", 4, 710, 1'b1);
    lit("hold_left_gap", 3, 710, 1'b0);
    lit("hold_right_edge", 59, 710, 1'b1);
    lit("hold_right_gap", 60, 710, 1'b0);
    lit("hold_bottom_edge", 4, 764, 1'b1);
    lit("hold_bottom_gap", 4, 765, 1'b0);
    lit("hold_top_gap", 4, 708, 1'b0);
    lit("hold_top_edge", 4, 709, 1'b1);

    // Camera change mid-frame must wait for the vblank latch.
    bus.screenx = -12'sd100;
    lit("no_tear", 4, 710, 1'b1);
    latch(-100, 0);
    lit("shift_in", 104, 710, 1'b1);
    lit("shift_left_gap", 103, 710, 1'b0);
    lit("shift_right_edge", 159, 710, 1'b1);
    lit("shift_right_gap", 160, 710, 1'b0);
    lit("shift_old_spot", 4, 710, 1'b0);
    for (int h = 90; h < 170; h++) pix(h, 710);

    // Far-left camera: world x is negative over the whole line.
    wr(33, 1'b1, 1100, 800);
    latch(-2000, 0);
    for (int h = 0; h < 1024; h++) pix(h, 710);
    lit("neg_wrap", 20, 710, 1'b0);

    // One pixel either side of the map's lower-left corner.
    latch(-1, 0);
    lit("wx_minus1", 0, 710, 1'b0);
    lit("wx_shift_left", 5, 710, 1'b1);
    latch(0, 2);
    lit("wy_minus1", 10, 767, 1'b0);
    lit("wy_shift", 10, 708, 1'b1);
    for (int h = 0; h < 70; h++) pix(h, 767);

    // Out-of-range writes, then a write racing the read of the same tile.
    latch(0, 0);
    wr(960, 1'b1, 1100, 800);
    wr(1029, 1'b1, 1100, 800);
    lit("oor_write", 324, 710, 1'b0);
    pix(324, 710);
    bus.map_we   = 1'b1;
    bus.map_addr = 11'd5;
    bus.map_data = 1'b1;
    pix(324, 710);
    bus.map_we   = 1'b0;
    pix(324, 710);
    @(negedge clk);
    check_bit("rdfirst_old", bus.exists, 1'b0);
    pix(324, 710);
    @(negedge clk);
    check_bit("rdfirst_new", bus.exists, 1'b1);
    lit("rdfirst_hold", 324, 710, 1'b1);

    // One-cycle reset mid-line: flush, then resume with the map intact.
    for (int h = 0; h < 20; h++) pix(h, 710);
    reset = 1'b1;
    pix(10, 710);
    reset = 1'b0;
    @(negedge clk);
    check_bit("midrst_exists", bus.exists, 1'b0);
    check_bit("midrst_blank_out", bus.blank_out, 1'b1);
    for (int h = 11; h < 40; h++) pix(h, 710);
    lit("after_reset_map_kept", 10, 710, 1'b1);
    lit("after_reset_tile5", 330, 720, 1'b1);

    pix(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
